// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

  // Iteration counter width for a given operand width (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/subtractor_nb.sv
// N-bit ripple subtractor: a + ~b + 1 through a chain of full-adder cells.
module subtractor_nb #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  logic [N:0]   carry;
  logic [N-1:0] b_inv;

  assign b_inv    = ~b;
  assign carry[0] = 1'b1;

  // Full-adder cell per bit; final carry-out high means a >= b.
  for (genvar i = 0; i < N; i++) begin : g_fa
    logic p;
    assign p          = a[i] ^ b_inv[i];
    assign diff[i]    = p ^ carry[i];
    assign carry[i+1] = (a[i] & b_inv[i]) | (carry[i] & p);
  end

  assign no_borrow = carry[N];

endmodule

// File: rtl/divider4b_seq.sv
// Sequential restoring unsigned divider with start/busy/done handshake.
module divider4b_seq
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t state, state_next;

  logic [WIDTH-1:0] q_work, q_work_next;
  logic [WIDTH-1:0] rem_work, rem_work_next;
  logic [WIDTH-1:0] divisor_r, divisor_r_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;
  logic             dbz_next;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic             take;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] step_rem;

  assign shifted = {rem_work, q_work[WIDTH-1]};

  subtractor_nb #(
    .N(WIDTH + 1)
  ) u_sub (
    .a        (shifted),
    .b        ({1'b0, divisor_r}),
    .diff     (trial),
    .no_borrow(no_borrow)
  );

  // trial msb is always zero when there is no borrow since rem < divisor.
  assign take     = no_borrow & ~trial[WIDTH];
  assign step_rem = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign step_q   = {q_work[WIDTH-2:0], take};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    q_work_next    = q_work;
    rem_work_next  = rem_work;
    divisor_r_next = divisor_r;
    cnt_next       = cnt;
    quotient_next  = quotient;
    remainder_next = remainder;
    dbz_next       = div_by_zero;
    case (state)
      IDLE: begin
        if (start) begin
          q_work_next    = dividend;
          divisor_r_next = divisor;
          rem_work_next  = '0;
          dbz_next       = 1'b0;
          if (divisor == '0) begin
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
            cnt_next       = '0;
          end else begin
            cnt_next = CW'(WIDTH - 1);
          end
        end
      end
      RUN: begin
        q_work_next   = step_q;
        rem_work_next = step_rem;
        if (cnt == '0) begin
          quotient_next  = step_q;
          remainder_next = step_rem;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Working, result and handshake registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_work      <= '0;
      rem_work    <= '0;
      divisor_r   <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      q_work      <= q_work_next;
      rem_work    <= rem_work_next;
      divisor_r   <= divisor_r_next;
      cnt         <= cnt_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= dbz_next;
      busy        <= (state_next == RUN);
      done        <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_divider4b_seq.sv
// Directed and exhaustive checks of divider4b_seq at WIDTH=4, plus a WIDTH=8 random regression.
module tb_divider4b_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  logic       start8;
  logic [7:0] dividend8, divisor8;
  logic       busy8, done8, dbz8;
  logic [7:0] quotient8, remainder8;

  int errors = 0;
  int checks = 0;

  divider4b_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  divider4b_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one op on the 4-bit DUT; returns cycles from accept edge to done and busy count.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit disturb,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = ~a; divisor = ~b;
    lat = 1; busy_cnt = 0;
    forever begin
      if (busy) busy_cnt++;
      if (done) break;
      if (lat > 40) begin
        checks++; errors++;
        $error("FAIL timeout4: observed=no_done expected=done");
        break;
      end
      if (disturb && busy_cnt == 2) begin
        start = 1'b1; dividend = 4'd2; divisor = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start8 = 1'b1; dividend8 = a; divisor8 = b;
    @(negedge clk);
    start8 = 1'b0; dividend8 = 8'($urandom); divisor8 = 8'($urandom);
    lat = 1;
    while (!done8) begin
      if (lat > 40) begin
        checks++; errors++;
        $error("FAIL timeout8: observed=no_done expected=done");
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    run_op(4'd13, 4'd3, 1'b0, lat, bc);
    check("13/3_lat", 32'(lat), 32'd5);
    check("13/3_busy", 32'(bc), 32'd4);
    check("13/3_q", 32'(quotient), 32'd4);
    check("13/3_r", 32'(remainder), 32'd1);
    check("13/3_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    check("13/3_done_pulse", 32'(done), 32'd0);

    run_op(4'd15, 4'd1, 1'b0, lat, bc);
    check("15/1_q", 32'(quotient), 32'd15);
    check("15/1_r", 32'(remainder), 32'd0);
    run_op(4'd5, 4'd7, 1'b0, lat, bc);
    check("5/7_q", 32'(quotient), 32'd0);
    check("5/7_r", 32'(remainder), 32'd5);
    run_op(4'd0, 4'd9, 1'b0, lat, bc);
    check("0/9_q", 32'(quotient), 32'd0);
    check("0/9_r", 32'(remainder), 32'd0);

    run_op(4'd11, 4'd0, 1'b0, lat, bc);
    check("11/0_lat", 32'(lat), 32'd1);
    check("11/0_busy", 32'(bc), 32'd0);
    check("11/0_q", 32'(quotient), 32'd15);
    check("11/0_r", 32'(remainder), 32'd11);
    check("11/0_dbz", 32'(div_by_zero), 32'd1);
    run_op(4'd13, 4'd3, 1'b0, lat, bc);
    check("dbz_cleared", 32'(div_by_zero), 32'd0);

    // Stray start plus operand churn while busy must not disturb 14/4.
    run_op(4'd14, 4'd4, 1'b1, lat, bc);
    check("14/4_lat", 32'(lat), 32'd5);
    check("14/4_q", 32'(quotient), 32'd3);
    check("14/4_r", 32'(remainder), 32'd2);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_q", 32'(quotient), 32'd3);
      check("hold_r", 32'(remainder), 32'd2);
      check("hold_done", 32'(done), 32'd0);
    end

    // Reset during the second RUN cycle.
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_q", 32'(quotient), 32'd0);
    check("midrst_r", 32'(remainder), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_nodone", 32'(done), 32'd0);
    run_op(4'd9, 4'd2, 1'b0, lat, bc);
    check("9/2_q", 32'(quotient), 32'd4);
    check("9/2_r", 32'(remainder), 32'd1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 1'b0, lat, bc);
        if (b == 0) begin
          check("exh_q", 32'(quotient), 32'd15);
          check("exh_r", 32'(remainder), 32'(a));
          check("exh_dbz", 32'(div_by_zero), 32'd1);
        end else begin
          check("exh_q", 32'(quotient), 32'(a / b));
          check("exh_r", 32'(remainder), 32'(a % b));
          check("exh_lat", 32'(lat), 32'd5);
        end
      end
    end

    for (int n = 0; n < 1000; n++) begin
      int a8, b8;
      a8 = int'($urandom_range(0, 255));
      b8 = int'($urandom_range(0, 255));
      if (n < 10) b8 = n;
      run_op8(8'(a8), 8'(b8), lat);
      if (b8 == 0) begin
        check("w8_q", 32'(quotient8), 32'd255);
        check("w8_r", 32'(remainder8), 32'(a8));
        check("w8_dbz", 32'(dbz8), 32'd1);
      end else begin
        check("w8_q", 32'(quotient8), 32'(a8 / b8));
        check("w8_r", 32'(remainder8), 32'(a8 % b8));
        check("w8_lat", 32'(lat), 32'd9);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
